pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and instruction-fetch sequencer. It owns the 16-bit PC, fetches one 32-bit instruction per cycle-sequence over a req/ack instruction-memory handshake, and presents each instruction to the core for execution. At the end of each instruction it consumes the branch unit's `st_flag`/`jmp_addr` pair to choose between a sequential and a redirected next PC. It drives `pc_hold` back to the branch unit, which keeps `st_flag` latched while `pc_hold` is high.

## Interface

Parameters:
- `RESET_ADDR`, default 16'h0000: PC value loaded on reset.
- `INSTR_W`, default 32: instruction width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  16  fetch address; always equals `pc`.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_ack`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  INSTR_W  fetched instruction.
- `instr`  out  INSTR_W  registered current instruction.
- `instr_valid`  out  1  one-cycle pulse: `instr` is newly loaded.
- `exec_done`  in  1  core has finished the current instruction.
- `st_flag`  in  1  branch unit requests a redirect.
- `jmp_addr`  in  16  redirect target.
- `halt`  in  1  stop fetching after the current instruction.
- `pc`  out  16  current program counter.
- `pc_hold`  out  1  high in EXEC; the branch unit holds `st_flag` while it is high.
- `halted`  out  1  high in HALT.

## Operation

- States: RST_IDLE, FETCH, DECODE, EXEC, HALT.
- RST_IDLE → FETCH unconditionally, one cycle after reset deasserts.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`: `instr` <= `imem_data`, go to DECODE.
  - Without ack: stay in FETCH, holding the request.
- DECODE: `instr_valid`=1 for exactly this cycle, then go to EXEC.
- EXEC: `pc_hold`=1. Wait for `exec_done`. On `exec_done`:
  - If `st_flag`=1: `pc` <= `jmp_addr`.
  - Otherwise: `pc` <= `pc`+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - Next state is HALT if `halt`=1 in the same cycle, else FETCH.
- HALT: terminal state; only `rst` leaves it. `pc` holds the updated value.
- `st_flag` and `jmp_addr` are sampled only in EXEC on the cycle `exec_done` is high. At all other times they are ignored.
- `imem_ack` outside FETCH is ignored. `instr` is unchanged.
- `halt` outside EXEC is ignored. It takes effect only at an instruction boundary, so an in-flight fetch always completes.
- `exec_done` outside EXEC is ignored.
- `rst` at any time, including mid-fetch or mid-EXEC, immediately forces the reset values below. An outstanding request is abandoned: `imem_req` drops asynchronously.

## Timing

- Reset values:
  - `pc`=`RESET_ADDR`, `instr`=0.
  - `instr_valid`=0, `imem_req`=0, `pc_hold`=0, `halted`=0.
  - State = RST_IDLE.
- All outputs are decoded from registered state and registers; there is no combinational input→output path.
- Minimum instruction period is 3 cycles: FETCH with ack in the same cycle, then DECODE, then EXEC with `exec_done` in the same cycle.
- Fetch latency is (ack cycle − FETCH entry) + 1.
- The new `pc` is visible the cycle after `exec_done`, in the same cycle `imem_req` reasserts.
- `pc_hold` falls in the cycle after `exec_done`, which lets the branch unit clear `st_flag` before the next EXEC.

## Test plan

- Reset then sequential run:
  - Stimulus: `RESET_ADDR`=16'h0010, ack in the same cycle as each request, `exec_done` on the first EXEC cycle, `st_flag`=0.
  - Required: `imem_addr` sequence 0x0010, 0x0011, 0x0012, one fetch every 3 cycles, one `instr_valid` pulse per instruction.
- Fetch wait states:
  - Stimulus: ack delayed 4 cycles.
  - Required: `imem_req` held for 5 cycles with a constant `imem_addr`; `instr` equals `imem_data` at the ack cycle.
  - Stimulus: a spurious ack during EXEC.
  - Required: ignored.
- Branch taken:
  - Stimulus: at `pc`=0x0020, `st_flag`=1 and `jmp_addr`=0x0100 with `exec_done`.
  - Required: next `imem_addr`=0x0100 and `pc_hold` falls the same cycle.
  - Stimulus: `st_flag`=1 pulsed without `exec_done`.
  - Required: no redirect.
- Wrap-around:
  - Stimulus: `pc`=0xFFFF, not taken.
  - Required: next `pc`=0x0000.
  - Stimulus: `pc`=0xFFFF, taken to 0xFFFF.
  - Required: `pc` stays 0xFFFF.
- Halt:
  - Stimulus: `halt` asserted during FETCH.
  - Required: the fetch completes.
  - Stimulus: `halt` and `exec_done` together at `pc`=0x0005.
  - Required: `pc`=0x0006, `halted`=1, no further `imem_req` until `rst`.
- Asynchronous reset mid-EXEC and mid-FETCH:
  - Stimulus: `rst` asserted in either state.
  - Required: all outputs are at their reset values before the next clock edge, and fetching restarts at `RESET_ADDR`.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer.
// Fetches over req/ack, presents instr, then takes a sequential or redirected next PC.
module pc_sequencer #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter int          INSTR_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [15:0]        imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               st_flag,
  input  logic [15:0]        jmp_addr,
  input  logic               halt,
  output logic [15:0]        pc,
  output logic               pc_hold,
  output logic               halted
);

  typedef enum logic [2:0] {
    RST_IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_req;
  logic               r_valid;
  logic               r_hold;
  logic               r_halted;
  logic [15:0]        w_pc_next;

  assign w_pc_next = st_flag ? jmp_addr : r_pc + 16'd1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RST_IDLE: w_next = FETCH;
      FETCH:    if (imem_ack) w_next = DECODE;
      DECODE:   w_next = EXEC;
      EXEC:     if (exec_done) w_next = halt ? HALT : FETCH;
      HALT:     w_next = HALT;
      default:  w_next = RST_IDLE;
    endcase
  end

  // Output flags are registered from the next state, so they track r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RST_IDLE;
      r_pc     <= RESET_ADDR;
      r_instr  <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_hold   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_req    <= (w_next == FETCH);
      r_valid  <= (w_next == DECODE);
      r_hold   <= (w_next == EXEC);
      r_halted <= (w_next == HALT);
      if (r_state == FETCH && imem_ack)
        r_instr <= imem_data;
      if (r_state == EXEC && exec_done)
        r_pc <= w_pc_next;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign imem_req    = r_req;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc_hold     = r_hold;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam logic [15:0] RA = 16'h0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        st_flag = 1'b0;
  logic [15:0] jmp_addr = '0;
  logic        halt = 1'b0;
  logic [15:0] pc;
  logic        pc_hold;
  logic        halted;

  int n_tot = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_ADDR(RA), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .st_flag(st_flag),
    .jmp_addr(jmp_addr), .halt(halt),
    .pc(pc), .pc_hold(pc_hold), .halted(halted)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: which phase of the instruction cycle we are in.
  localparam int S_BOOT = 0, S_FETCH = 1, S_DEC = 2, S_EXEC = 3, S_HALT = 4;
  int          m_st = S_BOOT;
  int          m_pc = int'(RA);
  logic [31:0] m_instr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= S_BOOT;
      m_pc <= int'(RA);
      m_instr <= '0;
    end else begin
      case (m_st)
        S_BOOT:  m_st <= S_FETCH;
        S_FETCH: if (imem_ack) begin
          m_instr <= imem_data;
          m_st <= S_DEC;
        end
        S_DEC:   m_st <= S_EXEC;
        S_EXEC:  if (exec_done) begin
          m_pc <= st_flag ? int'(jmp_addr) : (m_pc + 1) % 65536;
          m_st <= halt ? S_HALT : S_FETCH;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req", 32'(imem_req), 32'(m_st == S_FETCH));
      chk("m_addr", 32'(imem_addr), 32'(m_pc));
      chk("m_pc", 32'(pc), 32'(m_pc));
      chk("m_instr", instr, m_instr);
      chk("m_valid", 32'(instr_valid), 32'(m_st == S_DEC));
      chk("m_hold", 32'(pc_hold), 32'(m_st == S_EXEC));
      chk("m_halted", 32'(halted), 32'(m_st == S_HALT));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    chk("req_timeout", 32'(imem_req), 32'd1);
  endtask

  task automatic to_exec();
    imem_ack = 1'b1;
    exec_done = 1'b0;
    for (int i = 0; i < 20 && !pc_hold; i++) tick();
    chk("exec_timeout", 32'(pc_hold), 32'd1);
  endtask

  task automatic finish_exec(input logic st, input logic [15:0] ja,
                             input logic h);
    exec_done = 1'b1;
    st_flag = st;
    jmp_addr = ja;
    halt = h;
    tick();
    exec_done = 1'b0;
    st_flag = 1'b0;
    halt = 1'b0;
    imem_ack = 1'b0;
  endtask

  initial begin
    int nf, nv, okc, nreq, hc;
    int cyc[3];
    logic [15:0] a[3];
    logic [15:0] a0;
    logic [31:0] dprev, dsave;

    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_pc", 32'(pc), 32'h0010);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_hold", 32'(pc_hold), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // sequential run, ack and exec_done always ready
    imem_ack = 1'b1;
    exec_done = 1'b1;
    rst = 1'b0;
    nf = 0;
    nv = 0;
    dprev = '0;
    for (int s = 1; s <= 9; s++) begin
      tick();
      if (instr_valid) begin
        nv++;
        chk("seq_instr", instr, dprev);
      end
      imem_data = $urandom;
      if (imem_req) begin
        dprev = imem_data;
        if (nf < 3) begin
          a[nf] = imem_addr;
          cyc[nf] = s;
          nf++;
        end
      end
    end
    chk("seq_nf", 32'(nf), 32'd3);
    chk("seq_a0", 32'(a[0]), 32'h0010);
    chk("seq_a1", 32'(a[1]), 32'h0011);
    chk("seq_a2", 32'(a[2]), 32'h0012);
    chk("seq_gap1", 32'(cyc[1] - cyc[0]), 32'd3);
    chk("seq_gap2", 32'(cyc[2] - cyc[1]), 32'd3);
    chk("seq_nvalid", 32'(nv), 32'd3);

    // fetch wait states
    imem_ack = 1'b0;
    exec_done = 1'b1;
    wait_req();
    exec_done = 1'b0;
    a0 = imem_addr;
    okc = 0;
    dsave = '0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req && imem_addr == a0) okc++;
      imem_data = $urandom;
      if (i == 4) begin
        imem_ack = 1'b1;
        dsave = imem_data;
      end
      tick();
    end
    chk("wait_req_cycles", 32'(okc), 32'd5);
    chk("wait_addr", 32'(a0), 32'h0013);
    chk("wait_instr", instr, dsave);
    chk("wait_valid", 32'(instr_valid), 32'd1);
    chk("wait_req_drop", 32'(imem_req), 32'd0);

    // spurious ack during EXEC
    tick();
    chk("sp_hold", 32'(pc_hold), 32'd1);
    imem_data = ~dsave;
    tick();
    chk("sp_instr", instr, dsave);
    chk("sp_hold2", 32'(pc_hold), 32'd1);
    chk("sp_req", 32'(imem_req), 32'd0);

    // branch taken from 0x0020
    finish_exec(1'b1, 16'h0020, 1'b0);
    chk("br_pre_addr", 32'(imem_addr), 32'h0020);
    to_exec();
    finish_exec(1'b1, 16'h0100, 1'b0);
    chk("br_addr", 32'(imem_addr), 32'h0100);
    chk("br_hold_fall", 32'(pc_hold), 32'd0);
    chk("br_req", 32'(imem_req), 32'd1);

    // st_flag without exec_done
    to_exec();
    st_flag = 1'b1;
    jmp_addr = 16'h0abc;
    tick();
    st_flag = 1'b0;
    chk("nr_hold", 32'(pc_hold), 32'd1);
    finish_exec(1'b0, 16'h0bbb, 1'b0);
    chk("nr_pc", 32'(pc), 32'h0101);

    // wrap-around
    to_exec();
    finish_exec(1'b1, 16'hFFFF, 1'b0);
    to_exec();
    chk("wr_pc_ffff", 32'(pc), 32'h0000FFFF);
    finish_exec(1'b0, 16'h1234, 1'b0);
    chk("wr_seq", 32'(pc), 32'h0000);
    to_exec();
    finish_exec(1'b1, 16'hFFFF, 1'b0);
    to_exec();
    finish_exec(1'b1, 16'hFFFF, 1'b0);
    chk("wr_taken", 32'(pc), 32'h0000FFFF);

    // halt during FETCH lets the fetch complete
    halt = 1'b1;
    tick();
    tick();
    imem_ack = 1'b1;
    imem_data = 32'hA5A5_0F0F;
    tick();
    halt = 1'b0;
    chk("hf_valid", 32'(instr_valid), 32'd1);
    chk("hf_instr", instr, 32'hA5A5_0F0F);
    chk("hf_halted", 32'(halted), 32'd0);

    // halt at an instruction boundary
    to_exec();
    finish_exec(1'b1, 16'h0005, 1'b0);
    to_exec();
    chk("h_pc5", 32'(pc), 32'h0005);
    finish_exec(1'b0, 16'h7777, 1'b1);
    chk("h_pc6", 32'(pc), 32'h0006);
    chk("h_halted", 32'(halted), 32'd1);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      st_flag = 1'($urandom_range(0, 1));
      tick();
      if (imem_req) nreq++;
    end
    exec_done = 1'b0;
    st_flag = 1'b0;
    chk("h_noreq", 32'(nreq), 32'd0);
    chk("h_pc_hold", 32'(pc), 32'h0006);

    // asynchronous reset mid-EXEC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    to_exec();
    #2 rst = 1'b1;
    #1;
    chk("ar_e_pc", 32'(pc), 32'h0010);
    chk("ar_e_hold", 32'(pc_hold), 32'd0);
    chk("ar_e_instr", instr, 32'd0);
    chk("ar_e_req", 32'(imem_req), 32'd0);
    tick();
    rst = 1'b0;
    imem_ack = 1'b0;
    wait_req();
    chk("ar_e_restart", 32'(imem_addr), 32'h0010);

    // asynchronous reset mid-FETCH
    tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_f_req", 32'(imem_req), 32'd0);
    chk("ar_f_valid", 32'(instr_valid), 32'd0);
    chk("ar_f_halted", 32'(halted), 32'd0);
    tick();
    rst = 1'b0;
    wait_req();
    chk("ar_f_restart", 32'(imem_addr), 32'h0010);

    // random traffic
    hc = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = 1'b0;
      imem_ack = ($urandom_range(0, 9) < 6);
      imem_data = $urandom;
      exec_done = 1'($urandom_range(0, 1));
      st_flag = ($urandom_range(0, 9) < 3);
      jmp_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      halt = ($urandom_range(0, 49) == 0);
      if (m_st == S_HALT) begin
        hc++;
        if (hc > 3) begin
          rst = 1'b1;
          hc = 0;
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
